// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM request controller: FSM states, default
// geometry and the command bundle that is registered onto the macro pins.
package sram_ctrl_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Command bundle at the default geometry; the top re-declares the same
    // layout at its own parameterised widths.
    typedef struct packed {
        logic              men;
        logic              wen;
        logic              ren;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] din;
        logic [DEF_DW-1:0] bm;
    } sram_cmd_t;

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between a client and sram_req_ctrl.
interface sram_req_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_bm;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_bm, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_bm, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_rsp_fifo.sv
// Small synchronous show-ahead FIFO holding read data until the consumer
// takes it. Depth need not be a power of two; pointers wrap explicitly.
module sram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DW-1:0]              din_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    // Head entry is presented combinationally so rsp_valid/rsp_rdata line up.
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer wrap and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end
endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for a single-port SRAM macro: optional zero-fill
// sweep after reset, registered command pins, and credit-managed in-order
// read return through a small response FIFO.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int RD_LAT       = 1,
    parameter int RSP_DEPTH    = 3,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic           clk,
    input  logic           rst,
    sram_req_ctrl_if.slave bus,
    output logic           init_done,
    output logic [AW-1:0]  sram_addr,
    output logic [DW-1:0]  sram_din,
    output logic [DW-1:0]  sram_bm,
    output logic           sram_men,
    output logic           sram_wen,
    output logic           sram_ren,
    input  logic [DW-1:0]  sram_dout
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(RSP_DEPTH);
    localparam logic [AW-1:0] CLR_LAST = '1;

    typedef struct packed {
        logic          men;
        logic          wen;
        logic          ren;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] bm;
    } cmd_t;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    cmd_t              cmd_q, cmd_d;
    logic              init_done_q, init_done_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [CW:0]       credit_used;
    logic              req_ready_w, accept, rd_accept;

    // A read holds one credit from accept until the FIFO entry is popped, so
    // the FIFO can never be asked to absorb more than it holds.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign req_ready_w = init_done_q & (state_q == RUN) & ~fifo_full
                       & (credit_used < DEPTH_C);
    assign bus.req_ready = req_ready_w;
    assign rd_accept     = accept & ~bus.req_we;

    // Read-valid shift register tracking commands through the macro latency.
    genvar gi;
    for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
        if (gi == 0) begin : g_head
            assign rd_pipe_d[gi] = cmd_q.ren;
        end else begin : g_tail
            assign rd_pipe_d[gi] = rd_pipe_q[gi-1];
        end
    end

    assign fifo_push = rd_pipe_q[RD_LAT-1];
    assign fifo_pop  = bus.rsp_ready;

    // Next state, clear sweep address and the command to register onto the pins.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cmd_d      = cmd_q;
        cmd_d.men  = 1'b0;
        cmd_d.wen  = 1'b0;
        cmd_d.ren  = 1'b0;
        accept     = 1'b0;
        case (state_q)
            CLEAR: begin
                cmd_d.men  = 1'b1;
                cmd_d.wen  = 1'b1;
                cmd_d.addr = clr_addr_q;
                cmd_d.din  = '0;
                cmd_d.bm   = '1;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == CLR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                accept = bus.req_valid & req_ready_w;
                if (accept) begin
                    cmd_d.men  = 1'b1;
                    cmd_d.wen  = bus.req_we;
                    cmd_d.ren  = ~bus.req_we;
                    cmd_d.addr = bus.req_addr;
                    cmd_d.din  = bus.req_wdata;
                    cmd_d.bm   = bus.req_bm;
                end
            end
            default: state_d = CLEAR;
        endcase
        init_done_d = init_done_q | (state_d == RUN);
        inflight_d  = inflight_q + CW'(rd_accept) - CW'(fifo_push);
    end

    // State register; reset also drops in-flight reads and any pending command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
            clr_addr_q  <= '0;
            cmd_q       <= '0;
            init_done_q <= 1'b0;
            inflight_q  <= '0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            inflight_q  <= inflight_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (DW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (sram_dout),
        .pop_i   (fifo_pop),
        .dout_o  (bus.rsp_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.rsp_valid = ~fifo_empty;
    assign init_done     = init_done_q;
    assign sram_men      = cmd_q.men;
    assign sram_wen      = cmd_q.wen;
    assign sram_ren      = cmd_q.ren;
    assign sram_addr     = cmd_q.addr;
    assign sram_din      = cmd_q.din;
    assign sram_bm       = cmd_q.bm;
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl with a 16-word behavioural SRAM (1-cycle read).
// Expected read data is pushed to a queue at accept and compared on return.
module tb_sram_req_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_bm, sram_dout;
    logic          sram_men, sram_wen, sram_ren;

    sram_req_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_req_ctrl #(
        .AW(AW), .DW(DW), .RD_LAT(1), .RSP_DEPTH(3), .CLEAR_ON_RST(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_bm   (sram_bm),
        .sram_men  (sram_men),
        .sram_wen  (sram_wen),
        .sram_ren  (sram_ren),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM, seeded with non-zero garbage so the clear sweep matters.
    logic [31:0] sram_mem [16];
    bit          seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= 32'hA5A5_0000 | 32'(i);
            seeded <= 1'b1;
        end else begin
            if (sram_men && sram_wen)
                sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
            if (sram_men && sram_ren)
                sram_dout <= sram_mem[sram_addr];
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          rsp_cnt = 0;
    int          clr_cnt = 0;
    logic [15:0] clr_mask = '0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [16];

    task automatic monitor();
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (sram_men === 1'b1 && sram_wen === 1'b1 && sram_din === 32'h0 && sram_bm === ONES) begin
                clr_cnt++;
                clr_mask[sram_addr] = 1'b1;
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                checks++;
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %h, required no response", bus.rsp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.rsp_rdata !== exp) begin
                        errors++;
                        $display("FAIL rsp_data: got %h, required %h", bus.rsp_rdata, exp);
                    end else begin
                        $display("rsp data=%h ok", bus.rsp_rdata);
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] m, output int waited);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_bm    = m;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
        end else begin
            $display("req %s addr=%0d wdata=%h bm=%h", we ? "WR" : "RD", a, d, m);
            if (we) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            else    exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(output int left);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) begin @(posedge clk); #1; end
        left = exp_q.size();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic start_sweep();
        @(posedge clk); #1;
        rst      = 1'b0;
        clr_cnt  = 0;
        clr_mask = '0;
        foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    endtask

    task automatic test_reset();
        int n, w, left;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_bm = '0;   bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({init_done, bus.req_ready, bus.rsp_valid, sram_men, sram_wen, sram_ren} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: init/rdy/rvalid/men/wen/ren=%b, required 000000",
                     {init_done, bus.req_ready, bus.rsp_valid, sram_men, sram_wen, sram_ren});
        end
        checks++;
        if (sram_addr !== 4'h0 || sram_din !== 32'h0 || sram_bm !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h din=%h bm=%h, required 0/0/0", sram_addr, sram_din, sram_bm);
        end
        start_sweep();
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clear_len: init_done after %0d cycles, required 16", n);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clear: req_ready=%b, required 1", bus.req_ready);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (clr_cnt !== 16 || clr_mask !== 16'hFFFF) begin
            errors++;
            $display("FAIL clear_writes: count=%0d mask=%h, required 16/ffff", clr_cnt, clr_mask);
        end
        @(posedge clk); #1;
        for (int a = 0; a < 16; a++) issue(1'b0, 4'(a), 32'h0, 32'h0, w);
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL clear_read_drain: %0d responses missing, required 0", left);
        end
    endtask

    task automatic test_write_read();
        int w, left;
        issue(1'b1, 4'd3, 32'hDEAD_BEEF, ONES, w);
        issue(1'b0, 4'd3, 32'h0, 32'h0, w);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_lat_1: rsp_valid=%b one cycle after accept, required 0", bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_lat_2: rsp_valid=%b at accept+2 edges minus one, required 0", bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_lat_data: valid=%b data=%h, required 1/deadbeef", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge clk); #1;
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL write_read_drain: %0d missing, required 0", left);
        end
    endtask

    task automatic test_byte_mask();
        int w, n;
        issue(1'b1, 4'd5, ONES, ONES, w);
        issue(1'b1, 4'd5, 32'h0, 32'h0000_FF00, w);
        issue(1'b0, 4'd5, 32'h0, 32'h0, w);
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFF_00FF) begin
            errors++;
            $display("FAIL byte_mask: valid=%b data=%h, required 1/ffff00ff", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge clk); #1;
        drain(n);
    endtask

    task automatic test_backpressure();
        int w, idx, left, base;
        logic [3:0] list [5];
        list[0] = 4'd3; list[1] = 4'd5; list[2] = 4'd7; list[3] = 4'd1; list[4] = 4'd9;
        issue(1'b1, 4'd7, 32'h0707_0707, ONES, w);
        issue(1'b1, 4'd9, 32'h0909_0909, ONES, w);
        base = rsp_cnt;
        bus.rsp_ready = 1'b0;
        idx = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = list[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1 && idx < 5) begin
                exp_q.push_back(ref_mem[list[idx]]);
                $display("req RD addr=%0d (back-pressure)", list[idx]);
                idx++;
                @(posedge clk); #1;
                if (idx < 5) bus.req_addr = list[idx];
                else         bus.req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        checks++;
        if (idx !== 3) begin
            errors++;
            $display("FAIL bp_accepted: %0d reads accepted, required 3", idx);
        end
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: req_ready=%b rsp_valid=%b, required 0/1", bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                exp_q.push_back(ref_mem[list[idx]]);
                $display("req RD addr=%0d (resume)", list[idx]);
                idx++;
                @(posedge clk); #1;
                if (idx < 5) bus.req_addr = list[idx];
                else         bus.req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.req_valid = 1'b0;
        drain(left);
        checks++;
        if (left !== 0 || (rsp_cnt - base) !== 5) begin
            errors++;
            $display("FAIL bp_drain: missing=%0d returned=%0d, required 0/5", left, rsp_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int w, stalls, left, base;
        stalls = 0;
        base = rsp_cnt;
        for (int k = 0; k < 8; k++) begin
            issue(1'b1, 4'(k), 32'(k) * 32'h11, ONES, w);
            stalls += w;
            issue(1'b0, 4'(k), 32'h0, 32'h0, w);
            stalls += w;
        end
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL b2b_ready: %0d stall cycles, required 0", stalls);
        end
        drain(left);
        checks++;
        if (left !== 0 || (rsp_cnt - base) !== 8) begin
            errors++;
            $display("FAIL b2b_drain: missing=%0d returned=%0d, required 0/8", left, rsp_cnt - base);
        end
    endtask

    task automatic test_reset_midstream();
        int w, n, left, base;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd3, 32'h0, 32'h0, w);
        issue(1'b0, 4'd5, 32'h0, 32'h0, w);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.req_ready, init_done, sram_men} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: rvalid/rdy/init/men=%b, required 0000",
                     {bus.rsp_valid, bus.req_ready, init_done, sram_men});
        end
        exp_q.delete();
        bus.rsp_ready = 1'b1;
        base = rsp_cnt;
        @(posedge clk);
        start_sweep();
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL mid_clear_len: init_done after %0d cycles, required 16", n);
        end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (clr_cnt !== 16 || (rsp_cnt - base) !== 0) begin
            errors++;
            $display("FAIL mid_stale: clear writes=%0d stale responses=%0d, required 16/0", clr_cnt, rsp_cnt - base);
        end
        issue(1'b0, 4'd3, 32'h0, 32'h0, w);
        drain(left);
        checks++;
        if (left !== 0 || (rsp_cnt - base) !== 1) begin
            errors++;
            $display("FAIL mid_resume: missing=%0d returned=%0d, required 0/1", left, rsp_cnt - base);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_write_read();
        test_byte_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
